fetch_unit: RTL and testbench

//   Instruction fetch stage feeding the main decoder. Holds the PC and issues one

---
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch stage: PC register, imem req/ready/rvalid handshake, decode handoff.
// Optional performance counters are compiled in when FETCH_PERF_EN is defined.

module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ready_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  input  logic            PCSrc_i,
  input  logic [XLEN-1:0] ImmExt_i,
  output logic            misalign_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetch_cnt_o,
  output logic [31:0]     perf_stall_cnt_o
`endif
);

  // state   | meaning
  // S_FETCH | request outstanding on imem, address = pc
  // S_WAIT  | request accepted, waiting for rvalid
  // S_VALID | instruction presented to decode, held until instr_ready_i
  // S_ERR   | redirect target misaligned; parked until reset
  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_VALID, S_ERR} state_t;

  state_t          state;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_next;
  logic [31:0]     instr_q;
  logic            req_q;
  logic            valid_q;
  logic            mis_q;

  assign pc_next = PCSrc_i ? (pc_q + ImmExt_i) : (pc_q + XLEN'(4));

  // req_q stays low through reset and rises on the first clock in S_FETCH.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= S_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (req_q && imem_ready_i) begin
            req_q <= 1'b0;
            state <= S_WAIT;
          end else begin
            req_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            instr_q <= imem_rdata_i;
            valid_q <= 1'b1;
            state   <= S_VALID;
          end
        end
        S_VALID: begin
          if (instr_ready_i) begin
            valid_q <= 1'b0;
            pc_q    <= pc_next;
            if (pc_next[1:0] != 2'b00) begin
              mis_q <= 1'b1;
              state <= S_ERR;
            end else begin
              req_q <= 1'b1;
              state <= S_FETCH;
            end
          end
        end
        S_ERR:   state <= S_ERR;
        default: state <= S_FETCH;
      endcase
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = pc_q;
  assign instr_o       = instr_q;
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_q + XLEN'(4);
  assign instr_valid_o = valid_q;
  assign misalign_o    = mis_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (state == S_VALID && instr_ready_i)
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (state == S_FETCH || state == S_WAIT || (state == S_VALID && !instr_ready_i))
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt_o = fetch_cnt_q;
  assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: sequencing, stalls, redirects, wrap, misalign and reset abandonment.

module tb_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic        PCSrc_i;
  logic [31:0] ImmExt_i;
  logic        misalign_o;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt_o;
  logic [31:0] perf_stall_cnt_o;
`endif

  int checks   = 0;
  int failures = 0;

  fetch_unit dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ready_i  (imem_ready_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .PCSrc_i       (PCSrc_i),
    .ImmExt_i      (ImmExt_i),
    .misalign_o    (misalign_o)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt_o (perf_fetch_cnt_o),
    .perf_stall_cnt_o (perf_stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts in FETCH with req high; ends in VALID with the response presented.
  task automatic issue(input logic [31:0] addr, input logic [31:0] data);
    chk("fetch_req", {31'd0, imem_req_o}, 32'd1);
    chk("fetch_addr", imem_addr_o, addr);
    imem_ready_i = 1'b1;
    step();
    imem_ready_i = 1'b0;
    chk("wait_req", {31'd0, imem_req_o}, 32'd0);
    chk("wait_valid", {31'd0, instr_valid_o}, 32'd0);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = data;
    step();
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'hDEAD_BEEF;
    chk("valid", {31'd0, instr_valid_o}, 32'd1);
    chk("instr", instr_o, data);
    chk("pc", pc_o, addr);
    chk("pc_plus4", pc_plus4_o, addr + 32'd4);
  endtask

  task automatic accept(input logic pcsrc, input logic [31:0] imm);
    instr_ready_i = 1'b1;
    PCSrc_i       = pcsrc;
    ImmExt_i      = imm;
    step();
    instr_ready_i = 1'b0;
    PCSrc_i       = 1'b0;
    ImmExt_i      = '0;
    chk("accept_valid", {31'd0, instr_valid_o}, 32'd0);
  endtask

  initial begin
    rst_n_i       = 1'b0;
    imem_ready_i  = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    instr_ready_i = 1'b0;
    PCSrc_i       = 1'b0;
    ImmExt_i      = '0;
    step();
    step();

    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_plus4", pc_plus4_o, 32'h4);
    chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_mis", {31'd0, misalign_o}, 32'd0);

    rst_n_i = 1'b1;
    step();

    // Sequential fetches: FETCH, WAIT, VALID per instruction.
    issue(32'h0, 32'h0000_0013); accept(1'b0, 32'h0);
    issue(32'h4, 32'h0010_0093); accept(1'b0, 32'h0);
    issue(32'h8, 32'h0020_0113); accept(1'b0, 32'h0);

    // Memory not ready: request and address held.
    for (int i = 0; i < 4; i++) begin
      step();
      chk("hold_req", {31'd0, imem_req_o}, 32'd1);
      chk("hold_addr", imem_addr_o, 32'hC);
      chk("hold_valid", {31'd0, instr_valid_o}, 32'd0);
    end
    issue(32'hC, 32'h0030_0193); accept(1'b0, 32'h0);

    // Backward branch from 0x10 by -8.
    issue(32'h10, 32'hFE00_0CE3); accept(1'b1, 32'hFFFF_FFF8);
    chk("branch_addr", imem_addr_o, 32'h8);

    // Decode stall with PCSrc/ImmExt toggling.
    issue(32'h8, 32'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      PCSrc_i  = i[0];
      ImmExt_i = 32'h100;
      step();
      chk("stall_valid", {31'd0, instr_valid_o}, 32'd1);
      chk("stall_instr", instr_o, 32'h1234_5678);
      chk("stall_pc", pc_o, 32'h8);
      chk("stall_req", {31'd0, imem_req_o}, 32'd0);
    end
    accept(1'b1, 32'hFFFF_FFF4);
    chk("jump_wrap_addr", imem_addr_o, 32'hFFFF_FFFC);

    // PC wrap on +4.
    issue(32'hFFFF_FFFC, 32'h0000_006F);
    chk("wrap_plus4", pc_plus4_o, 32'h0);
    accept(1'b0, 32'h0);
    chk("wrap_addr", imem_addr_o, 32'h0);

    // Misaligned redirect parks the unit.
    issue(32'h0, 32'h0060_006F);
    accept(1'b1, 32'h6);
    chk("err_mis", {31'd0, misalign_o}, 32'd1);
    chk("err_pc", pc_o, 32'h6);
    imem_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      imem_rvalid_i = i[0];
      step();
      chk("err_req", {31'd0, imem_req_o}, 32'd0);
      chk("err_valid", {31'd0, instr_valid_o}, 32'd0);
      chk("err_mis_sticky", {31'd0, misalign_o}, 32'd1);
    end
    imem_ready_i  = 1'b0;
    imem_rvalid_i = 1'b0;

    rst_n_i = 1'b0;
    #1;
    chk("rst2_mis", {31'd0, misalign_o}, 32'd0);
    chk("rst2_addr", imem_addr_o, 32'h0);
    step();
    rst_n_i = 1'b1;
    step();

    // Reset while WAIT; late rvalid must be dropped.
    chk("re_req", {31'd0, imem_req_o}, 32'd1);
    imem_ready_i = 1'b1;
    step();
    imem_ready_i = 1'b0;
    chk("re_wait_req", {31'd0, imem_req_o}, 32'd0);
    rst_n_i = 1'b0;
    step();
    rst_n_i       = 1'b1;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hBAD0_BAD0;
    step();
    imem_rvalid_i = 1'b0;
    chk("stale_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("stale_addr", imem_addr_o, 32'h0);
    issue(32'h0, 32'h0000_0033);
    accept(1'b0, 32'h0);
    chk("post_addr", imem_addr_o, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
